// File: rtl/matrix_3x3_gen.sv
// ----------------------------------------------------------------------------
// matrix_3x3_gen
// Builds a sliding 3x3 window over a raster stream of gradient magnitudes.
// Two line buffers hold the previous two rows. One window is issued per
// accepted pixel from frame row 2 onward. Border windows are flagged through
// data_valid rather than padded.
//
// Ports
//   clk                 in   system clock
//   rst_n               in   synchronous reset, active low
//   start               in   function enable; low clears counters and window
//   data_en             in   pixel strobe; start && data_en accepts a pixel
//   data                in   DATA_WIDTH pixel, raster order
//   matrix_p11..p33     out  window; row 1 = oldest row, col 1 = oldest col
//   matrix_clken        out  window strobe, one cycle after acceptance
//   data_valid          out  1 = window straddles a row start (unusable)
//   start_sync          out  start delayed by one cycle
//   frame_done          out  pulse with the window of the last frame pixel
// ----------------------------------------------------------------------------
module matrix_3x3_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int DEPTH      = 504
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  matrix_clken,
    output logic                  data_valid,
    output logic                  start_sync,
    output logic                  frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_lb1 [WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [WIDTH];

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_lb1_rd;
    logic [DATA_WIDTH-1:0] w_lb2_rd;

    assign w_accept   = start & data_en;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    // Rows 0 and 1 only fill the line buffers, which also keeps stale
    // buffer contents from a previous run from ever being emitted.
    assign w_emit     = w_accept && (r_row >= RW'(2));
    assign w_lb1_rd   = r_lb1[r_col];
    assign w_lb2_rd   = r_lb2[r_col];

    // Column / row position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (data_en) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers, read-before-write: lb1 row moves down into lb2. Not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= w_lb1_rd;
            r_lb1[r_col] <= data;
        end
    end

    // Window shift register and output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n || !start) begin
            matrix_p11   <= '0;
            matrix_p12   <= '0;
            matrix_p13   <= '0;
            matrix_p21   <= '0;
            matrix_p22   <= '0;
            matrix_p23   <= '0;
            matrix_p31   <= '0;
            matrix_p32   <= '0;
            matrix_p33   <= '0;
            matrix_clken <= 1'b0;
            data_valid   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                matrix_p11 <= matrix_p12;
                matrix_p12 <= matrix_p13;
                matrix_p13 <= w_lb2_rd;
                matrix_p21 <= matrix_p22;
                matrix_p22 <= matrix_p23;
                matrix_p23 <= w_lb1_rd;
                matrix_p31 <= matrix_p32;
                matrix_p32 <= matrix_p33;
                matrix_p33 <= data;
            end
            matrix_clken <= w_emit;
            // Centre column is col-1; col 0 or 1 means the window wraps
            // across the previous row end.
            data_valid   <= w_emit && (r_col < CW'(2));
            frame_done   <= w_emit && w_col_last && w_row_last;
        end
    end

    // Start aligned with the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_sync <= 1'b0;
        end else begin
            start_sync <= start;
        end
    end

endmodule

// File: tb/tb_matrix_3x3_gen.sv
module tb_matrix_3x3_gen;

    localparam int W = 8;
    localparam int D = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        data_en;
    logic [15:0] data;
    logic [15:0] matrix_p11, matrix_p12, matrix_p13;
    logic [15:0] matrix_p21, matrix_p22, matrix_p23;
    logic [15:0] matrix_p31, matrix_p32, matrix_p33;
    logic        matrix_clken, data_valid, start_sync, frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int usable   = 0;
    int fd_cnt   = 0;

    // Every pixel accepted since the last counter restart, in arrival order.
    logic [15:0] stream [$];

    matrix_3x3_gen #(.DATA_WIDTH(16), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_en(data_en), .data(data),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .matrix_clken(matrix_clken), .data_valid(data_valid),
        .start_sync(start_sync), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle and check the outputs it produces.
    task automatic step(input logic rn, input logic st, input logic en, input logic [15:0] d);
        logic [15:0] ob [9];
        int k, row, col;
        logic e_clk, e_val, e_fd;
        rst_n = rn; start = st; data_en = en; data = d;
        @(posedge clk);
        #1;
        ob = '{matrix_p11, matrix_p12, matrix_p13,
               matrix_p21, matrix_p22, matrix_p23,
               matrix_p31, matrix_p32, matrix_p33};
        chk("start_sync", start_sync, rn ? st : 1'b0);
        e_clk = 1'b0; e_val = 1'b0; e_fd = 1'b0;
        if (!rn || !st) begin
            stream.delete();
            for (int i = 0; i < 9; i++) chk("win_clear", ob[i], 32'd0);
        end else if (en) begin
            stream.push_back(d);
            k   = stream.size() - 1;
            row = (k / W) % D;
            col = k % W;
            e_clk = (row >= 2);
            e_val = e_clk && (col < 2);
            e_fd  = (row == D - 1) && (col == W - 1);
            // Window element (i,j) is the pixel (2-j) columns and (2-i) rows back.
            if (e_clk && !e_val)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        chk("win", ob[i*3+j], stream[k - (2 - j) - (2 - i) * W]);
        end
        chk("clken", matrix_clken, e_clk);
        chk("data_valid", data_valid, e_val);
        chk("frame_done", frame_done, e_fd);
        if (matrix_clken && !data_valid) usable++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic pat(input int r, input int c);
        step(1'b1, 1'b1, 1'b1, 16'(r * 16 + c));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; data_en = 1'b0; data = 16'h0000;
        // Reset state, also with start/data_en high.
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h1234);

        // Two back-to-back pattern frames, 3 idle cycles inside row 3 of frame 1.
        usable = 0; fd_cnt = 0;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < D; r++)
                for (int c = 0; c < W; c++) begin
                    if (f == 0 && r == 3 && c == 3) repeat (3) step(1'b1, 1'b1, 1'b0, 16'hdead);
                    pat(r, c);
                    if (r == 2 && c == 0) chk("row2_col0_invalid", data_valid, 32'd1);
                    if (r == 2 && c == 2) begin
                        chk("s2_p11", matrix_p11, 32'h00); chk("s2_p13", matrix_p13, 32'h02);
                        chk("s2_p21", matrix_p21, 32'h10); chk("s2_p22", matrix_p22, 32'h11);
                        chk("s2_p33", matrix_p33, 32'h22); chk("s2_valid", data_valid, 32'd0);
                    end
                    if (r == D - 1 && c == W - 1) begin
                        chk("fd_p22", matrix_p22, 32'h46);
                        chk("usable_per_frame", usable, (W - 2) * (D - 2));
                        usable = 0;
                    end
                end
        chk("frame_done_count", fd_cnt, 32'd2);

        // Start dropped at row 3 col 4, then re-raised from a fresh frame.
        for (int k = 0; k < 3 * W + 4; k++) pat(k / W, k % W);
        step(1'b1, 1'b0, 1'b1, 16'h0034);
        chk("drop_clken", matrix_clken, 32'd0);
        for (int k = 0; k < 4 * W + 3; k++) pat(k / W, k % W);

        // One-cycle reset in row 4, then a full frame.
        step(1'b0, 1'b1, 1'b1, 16'h0043);
        chk("rst_p33", matrix_p33, 32'd0);
        usable = 0;
        for (int k = 0; k < W * D; k++) pat(k / W, k % W);
        chk("usable_after_rst", usable, (W - 2) * (D - 2));

        // Random data, gaps, start drops and resets.
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 59) != 0,
                 $urandom_range(0, 3) != 0, 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
